// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan driver.
//   digit_t   - one BCD/hex code (4 bits)
//   seg_t     - one segment pattern, active-high, bit0=A .. bit6=G
//   SEG_*     - glyph constants for codes 0-9, A-F and blank
//   SEG_*_BIT - segment bit positions within seg_t
package seg7_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam int unsigned SEG_A_BIT = 0;
    localparam int unsigned SEG_B_BIT = 1;
    localparam int unsigned SEG_C_BIT = 2;
    localparam int unsigned SEG_D_BIT = 3;
    localparam int unsigned SEG_E_BIT = 4;
    localparam int unsigned SEG_F_BIT = 5;
    localparam int unsigned SEG_G_BIT = 6;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational code-to-segment lookup.
// Configuration macro: SEG7_HEX_EN - when defined, codes 10-15 show hex glyphs
// A b C d E F; otherwise they are blank.
// Ports:
//   digit  in  4  code to display
//   seg    out 7  segment pattern, active-high, bit0=A .. bit6=G
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10:   seg = SEG_A;
            4'd11:   seg = SEG_B;
            4'd12:   seg = SEG_C;
            4'd13:   seg = SEG_D;
            4'd14:   seg = SEG_E;
            4'd15:   seg = SEG_F;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed multi-digit seven-segment driver.
// Scans NUM_DIGITS shadow digits, one per REFRESH_DIV-clock slot, with the first
// BLANK_CYCLES clocks of every slot dark (anti-ghost). New data is staged in a
// pending register and only copied to the shadow at the frame wrap so a frame is
// never torn. Optional leading-zero suppression. Outputs are registered.
// Configuration macro: SEG7_HEX_EN (in seg7_decode) enables hex glyphs for 10-15.
// Ports:
//   clk         in   1              system clock
//   rst_n       in   1              asynchronous active-low reset
//   digits_in   in   4*NUM_DIGITS   packed codes, [3:0] = digit 0
//   dp_in       in   NUM_DIGITS     decimal-point request per digit
//   load        in   1              capture strobe for digits_in/dp_in
//   lz_blank    in   1              1 = suppress leading zeros
//   seg_out     out  7              segments, active-high, bit0=A .. bit6=G
//   dp_out      out  1              decimal point, active-high
//   an_out      out  NUM_DIGITS     one-hot digit enable, active-high
//   frame_done  out  1              one-cycle pulse at each scan wrap
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    cnt_tc;
    logic                    wrap;
    logic                    in_blank;
    logic [NUM_DIGITS-1:0]   supp_mask;
    logic                    zero_above;
    digit_t                  cur_digit;
    logic                    cur_dp;
    logic                    cur_supp;
    seg_t                    dec_seg;

    // Slot timing
    assign cnt_tc   = (cnt_q == CntW'(REFRESH_DIV - 1));
    assign wrap     = cnt_tc && (idx_q == IdxW'(NUM_DIGITS - 1));
    assign in_blank = (32'(cnt_q) < BLANK_CYCLES);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
        if (cnt_tc) begin
            cnt_d = '0;
            idx_d = wrap ? '0 : idx_q + IdxW'(1);
        end
    end

    // Pending/shadow update: shadow changes only at the frame wrap. A load on the
    // wrap edge itself bypasses pending so it is not delayed a whole frame.
    always_comb begin
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_vld_d  = pend_vld_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        if (wrap) begin
            if (load) begin
                shadow_d    = digits_in;
                shadow_dp_d = dp_in;
            end else if (pend_vld_q) begin
                shadow_d    = pend_q;
                shadow_dp_d = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_d     = digits_in;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
    end

    // Digit k (k > 0) is suppressible when it and every higher digit are zero.
    always_comb begin
        supp_mask  = '0;
        zero_above = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            zero_above   = zero_above & (shadow_q[4*k +: 4] == 4'd0);
            supp_mask[k] = zero_above;
        end
    end

    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_supp  = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_digit = shadow_q[4*i +: 4];
                cur_dp    = shadow_dp_q[i];
                cur_supp  = supp_mask[i];
            end
        end
    end

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // Suppressed digits keep their enable and decimal point, only segments go dark
    always_comb begin
        an_d         = '0;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b0;
        frame_done_d = wrap;
        if (!in_blank) begin
            an_d  = NUM_DIGITS'(1) << idx_q;
            seg_d = (lz_blank && cur_supp) ? SEG_BLANK : dec_seg;
            dp_d  = cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
// Each frame is 16 clocks: per slot one dark clock followed by three lit clocks.
module tb_seg7_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int checks;
    int errors;

`ifdef SEG7_HEX_EN
    localparam logic [6:0] GLYPH_C = 7'h39;
`else
    localparam logic [6:0] GLYPH_C = 7'h00;
`endif

    seg7_scan_mux #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks one full frame, starting at the sample where frame_done was just seen
    // (or right after reset release). exp_seg packs {d3,d2,d1,d0} glyphs, 7 bits each.
    // do_load pulses load at the first clock of the frame; wrap_ld pulses it on the
    // wrap edge that ends the frame.
    task automatic check_frame(input string tag, input logic [27:0] exp_seg,
                               input logic [3:0] exp_dp, input logic do_load,
                               input logic wrap_ld, input logic [15:0] ld_dig,
                               input logic [3:0] ld_dp);
        logic [3:0] an_exp;
        if (do_load) begin
            digits_in = ld_dig;
            dp_in     = ld_dp;
            load      = 1'b1;
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            load = 1'b0;
            check({tag, " dark an"}, 32'(an_out), 32'h0);
            check({tag, " dark seg"}, 32'(seg_out), 32'h0);
            check({tag, " dark dp"}, 32'(dp_out), 32'h0);
            check({tag, " dark fd"}, 32'(frame_done), 32'h0);
            an_exp = 4'b0001 << s;
            for (int j = 0; j < 3; j++) begin
                if (wrap_ld && s == 3 && j == 2) begin
                    digits_in = ld_dig;
                    dp_in     = ld_dp;
                    load      = 1'b1;
                end
                @(negedge clk);
                check($sformatf("%s d%0d an", tag, s), 32'(an_out), 32'(an_exp));
                check($sformatf("%s d%0d seg", tag, s), 32'(seg_out), 32'(exp_seg[7*s +: 7]));
                check($sformatf("%s d%0d dp", tag, s), 32'(dp_out), 32'(exp_dp[s]));
            end
        end
        load = 1'b0;
        check({tag, " frame_done"}, 32'(frame_done), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        digits_in = 16'h0;
        dp_in     = 4'h0;
        load      = 1'b0;
        lz_blank  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst seg", 32'(seg_out), 32'h0);
        check("rst an", 32'(an_out), 32'h0);
        check("rst dp", 32'(dp_out), 32'h0);
        check("rst fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // Empty shadow: all digits show 0
        check_frame("idle", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 1'b0, 1'b0, 16'h0, 4'h0);

        // Mid-frame load is held until the frame boundary
        check_frame("ld1234 old", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 1'b1, 1'b0,
                    16'h1234, 4'b0000);
        check_frame("ld1234 new", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 1'b0, 1'b0,
                    16'h0, 4'h0);

        // Leading zeros, with a decimal point on a suppressed digit
        check_frame("ld0007 old", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 1'b1, 1'b0,
                    16'h0007, 4'b1000);
        lz_blank = 1'b1;
        check_frame("lz on", {7'h00, 7'h00, 7'h00, 7'h07}, 4'b1000, 1'b0, 1'b0, 16'h0, 4'h0);
        lz_blank = 1'b0;
        check_frame("lz off", {7'h3F, 7'h3F, 7'h3F, 7'h07}, 4'b1000, 1'b0, 1'b0, 16'h0, 4'h0);

        // Code 12 and a single decimal point
        check_frame("ld00C5 old", {7'h3F, 7'h3F, 7'h3F, 7'h07}, 4'b1000, 1'b1, 1'b0,
                    16'h00C5, 4'b0010);
        check_frame("ld00C5 new", {7'h3F, 7'h3F, GLYPH_C, 7'h6D}, 4'b0010, 1'b0, 1'b0,
                    16'h0, 4'h0);

        // Load exactly on the wrap edge goes straight to the shadow
        check_frame("wrap old", {7'h3F, 7'h3F, GLYPH_C, 7'h6D}, 4'b0010, 1'b0, 1'b1,
                    16'h9999, 4'b0000);
        check_frame("wrap new", {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 4'b0000, 1'b0, 1'b0,
                    16'h0, 4'h0);

        // Two loads in one frame: the later one is shown
        digits_in = 16'h1111;
        load      = 1'b1;
        @(negedge clk);
        digits_in = 16'h8642;
        @(negedge clk);
        load = 1'b0;
        repeat (14) @(negedge clk);
        check("last wins fd", 32'(frame_done), 32'h1);
        check_frame("last wins", {7'h7F, 7'h7D, 7'h66, 7'h5B}, 4'b0000, 1'b0, 1'b0,
                    16'h0, 4'h0);

        // Reset in the middle of digit 2's slot with a load pending
        digits_in = 16'h5555;
        dp_in     = 4'b1111;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-rst an", 32'(an_out), 32'h4);
        rst_n = 1'b0;
        #1;
        check("async seg", 32'(seg_out), 32'h0);
        check("async an", 32'(an_out), 32'h0);
        check("async dp", 32'(dp_out), 32'h0);
        check("async fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("post-rst 1", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 1'b0, 1'b0,
                    16'h0, 4'h0);
        check_frame("post-rst 2", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 1'b0, 1'b0,
                    16'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
